// File: rtl/phase_timer_if.sv
// Configuration bus for phase_timer: duration write strobe, index and value,
// plus the registered out-of-range error pulse returned to the config logic.
interface phase_timer_if #(
  parameter int NUM_PHASES = 3,
  parameter int CNT_W      = 7,
  parameter int IDX_W      = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) ();
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [CNT_W-1:0] cfg_dur;
  logic             cfg_err;

  modport master (output cfg_we, cfg_idx, cfg_dur, input cfg_err);
  modport slave  (input cfg_we, cfg_idx, cfg_dur, output cfg_err);
endinterface

// File: rtl/phase_timer.sv
// Per-phase duration timer: counts cycles of the one-hot selected phase, flags its
// last cycle, and commits shadowed durations only at phase boundaries or in IDLE.
module phase_timer #(
  parameter int NUM_PHASES = 3,
  parameter int CNT_W      = 7,
  parameter int DEF_DUR    = 10,
  parameter int IDX_W      = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_PHASES-1:0] phase_sel,
  input  logic                  set_mode,
  input  logic                  sync_clr,
  input  logic                  hold,
  phase_timer_if.slave          cfg,
  output logic [NUM_PHASES-1:0] phase_end,
  output logic                  any_end,
  output logic [CNT_W-1:0]      count,
  output logic [CNT_W-1:0]      remaining,
  output logic                  sel_err
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      shadow  [NUM_PHASES];
  logic [CNT_W-1:0]      dur_act [NUM_PHASES];
  logic [NUM_PHASES-1:0] wr_hit;
  logic [CNT_W-1:0]      sel_dur, term;
  logic                  at_term;

  assign sel_err = (phase_sel == '0) || ((phase_sel & (phase_sel - 1'b1)) != '0);

  // Duration 0 is treated as 1, so the terminal count never underflows.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    sel_dur = '0;
    wr_hit  = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (phase_sel[i]) sel_dur = sel_dur | dur_act[i];
      wr_hit[i] = cfg.cfg_we && (cfg.cfg_idx == IDX_W'(i));
    end
    term    = (sel_dur == '0) ? '0 : sel_dur - 1'b1;
    at_term = (count == term);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // sample the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (set_mode || sel_err) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = hold ? HOLD : RUN;
        HOLD:    state_next = hold ? HOLD : RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    phase_end = '0;
    remaining = '0;
    for (int i = 0; i < NUM_PHASES; i++)
      phase_end[i] = (state == RUN) && phase_sel[i] && at_term && !hold && !sync_clr && !set_mode;
    any_end = |phase_end;
    if (state != IDLE) remaining = term - count + 1'b1;
  end

  // Overshoot after a phase switch (count > term) clears like an end, minus the pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (set_mode || sel_err || state == IDLE || sync_clr) begin
      count <= '0;
    end else if (state == HOLD || hold) begin
      count <= count;
    end else if (count >= term) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // NOTE: the small duration arrays are reset because the timer must run with
  // DEF_DUR straight out of reset; a real RAM here would not be reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg.cfg_err <= 1'b0;
      for (int i = 0; i < NUM_PHASES; i++) begin
        shadow[i]  <= CNT_W'(DEF_DUR);
        dur_act[i] <= CNT_W'(DEF_DUR);
      end
    end else begin
      cfg.cfg_err <= cfg.cfg_we && (int'(cfg.cfg_idx) >= NUM_PHASES);
      for (int i = 0; i < NUM_PHASES; i++) begin
        if (wr_hit[i]) shadow[i] <= cfg.cfg_dur;
        if (wr_hit[i] && phase_end[i])
          dur_act[i] <= cfg.cfg_dur;
        else if (phase_end[i] || state == IDLE)
          dur_act[i] <= shadow[i];
      end
    end
  end

endmodule
